// File: rtl/mem_bus_pkg.sv
// Shared types for the single-word memory bus initiator.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        GAP
    } init_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Word-aligns the address and clears the byte mask on reads, so the bus
    // never sees a non-zero mask alongside mem_read.
    function automatic mem_req_t build_req(input logic        we,
                                           input logic [31:0] addr,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
        mem_req_t req;
        req.we    = we;
        req.addr  = addr & WORD_ALIGN_MASK;
        req.wdata = wdata;
        req.be    = we ? be : 4'b0000;
        return req;
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Core-side request/response handshake plus memory-side bus signals.
interface mem_bus_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        input  mem_rdata, mem_resp,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        output mem_rdata, mem_resp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );
endinterface

// File: rtl/mem_bus_watchdog.sv
// Saturating cycle counter that flags the last permitted strobe cycle.
module mem_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    // Count strobe cycles already elapsed; hold at the limit instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LP_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The current cycle is the TIMEOUT_CYCLES-th strobe cycle once r_cnt hits limit-1.
    assign o_timeout = i_en && (r_cnt >= (LP_LIMIT - 1'b1));

endmodule

// File: rtl/mem_bus_initiator.sv
// Load/store initiator for the single-word memory bus with timeout watchdog.
module mem_bus_initiator
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic      clk,
    input  logic      rst,
    mem_bus_if.master bus
);

    init_state_t r_state;
    init_state_t w_state_next;
    mem_req_t    r_req;
    mem_req_t    w_req_in;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_strobe;
    logic        w_timeout;
    logic        w_req_ready;
    logic        w_rsp_valid;
    logic        w_mem_read;
    logic        w_mem_write;

    assign w_req_in = build_req(bus.req_we, bus.req_addr, bus.req_wdata, bus.req_be);
    assign w_strobe = (r_state == READ) || (r_state == WRITE);

    mem_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_strobe),
        .i_en      (w_strobe),
        .o_timeout (w_timeout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs; a response wins over a coincident timeout.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = bus.req_we ? WRITE : READ;
                end
            end
            READ: begin
                w_mem_read = 1'b1;
                if (bus.mem_resp || w_timeout) begin
                    w_state_next = RESP;
                end
            end
            WRITE: begin
                w_mem_write = 1'b1;
                if (bus.mem_resp || w_timeout) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_rsp_valid  = 1'b1;
                w_state_next = GAP;
            end
            GAP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request latch on acceptance and response capture at the end of the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req <= w_req_in;
            end
            if (w_strobe) begin
                if (bus.mem_resp) begin
                    r_rdata <= (r_state == READ) ? bus.mem_rdata : 32'h0;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rdata <= 32'h0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready       = w_req_ready;
    assign bus.rsp_valid       = w_rsp_valid;
    assign bus.rsp_rdata       = r_rdata;
    assign bus.rsp_err         = r_err;
    assign bus.mem_read        = w_mem_read;
    assign bus.mem_write       = w_mem_write;
    assign bus.mem_address     = r_req.addr;
    assign bus.mem_wdata       = r_req.wdata;
    assign bus.mem_byte_enable = r_req.be;

`ifndef SYNTHESIS
    a_one_strobe: assert property (@(posedge clk) disable iff (rst)
        !(w_mem_read && w_mem_write));
    a_strobe_matches_req: assert property (@(posedge clk) disable iff (rst)
        w_strobe |-> (w_mem_write == r_req.we));
    a_bus_stable: assert property (@(posedge clk) disable iff (rst)
        (w_strobe && $past(w_strobe)) |->
        (r_req.addr == $past(r_req.addr) && r_req.wdata == $past(r_req.wdata)));
    a_no_early_drop: assert property (@(posedge clk) disable iff (rst)
        (w_strobe && !bus.mem_resp && !w_timeout) |=> w_strobe);
`endif

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and random traffic against a word-array reference model.
module tb_mem_bus_initiator;

    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_bus_if bus ();

    mem_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    logic [31:0] phys_mem [0:4095];
    logic [31:0] ref_mem  [0:4095];
    logic        preload_done = 1'b0;
    int          resp_delay   = 0;
    int          scnt         = 0;
    logic        bus_viol     = 1'b0;
    logic        prev_strobe  = 1'b0;
    logic [31:0] prev_addr    = '0;
    logic [31:0] prev_wdata   = '0;
    logic [3:0]  prev_be      = '0;

    wire strobe = bus.mem_read | bus.mem_write;

    assign bus.mem_resp  = strobe && (scnt == resp_delay);
    assign bus.mem_rdata = phys_mem[bus.mem_address[13:2]];

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B9;
    endfunction

    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 4096; i++) phys_mem[i] <= init_word(i);
            phys_mem[12'h48D] <= 32'hDEAD_BEEF;
            phys_mem[12'h010] <= 32'h1122_3344;
            preload_done <= 1'b1;
        end else if (bus.mem_write && bus.mem_resp) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_byte_enable[b])
                    phys_mem[bus.mem_address[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        scnt        <= strobe ? scnt + 1 : 0;
        prev_strobe <= strobe;
        prev_addr   <= bus.mem_address;
        prev_wdata  <= bus.mem_wdata;
        prev_be     <= bus.mem_byte_enable;
        if (bus.mem_read && bus.mem_write) bus_viol <= 1'b1;
        if (strobe && prev_strobe &&
            (bus.mem_address != prev_addr || bus.mem_wdata != prev_wdata ||
             bus.mem_byte_enable != prev_be))
            bus_viol <= 1'b1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: success iff the responder answers within T strobe cycles.
    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int delay,
                             output logic [31:0] e_rdata, output logic e_err, output int e_strobes);
        int          idx;
        logic [31:0] mask;
        idx       = int'(addr[13:2]);
        e_err     = (delay >= T);
        e_strobes = e_err ? T : delay + 1;
        e_rdata   = (we || e_err) ? 32'h0 : ref_mem[idx];
        if (we && !e_err) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            ref_mem[idx] = (ref_mem[idx] & ~mask) | (wdata & mask);
        end
    endtask

    // Issue one request from IDLE and follow it through RESP and GAP.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int delay,
                           output logic [31:0] rdata, output logic err, output int strobes);
        int   n;
        logic got;
        resp_delay = delay;
        rdata = '0; err = 1'b0; strobes = 0; got = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk({tag, "_ready_wait"}, 32'(bus.req_ready), 32'h1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!got && n < 300) begin
            if (bus.rsp_valid) begin
                got   = 1'b1;
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
            end else begin
                if (strobe) begin
                    strobes++;
                    if (strobes == 1) begin
                        chk({tag, "_strobe_kind"}, 32'({bus.mem_read, bus.mem_write}),
                            we ? 32'h1 : 32'h2);
                        chk({tag, "_addr"}, bus.mem_address, addr & 32'hFFFF_FFFC);
                        chk({tag, "_be"}, 32'(bus.mem_byte_enable), we ? 32'(be) : 32'h0);
                        if (we) chk({tag, "_wdata"}, bus.mem_wdata, wdata);
                    end
                end
                @(negedge clk);
                n++;
            end
        end
        if (!got) chk({tag, "_rsp_seen"}, 32'(got), 32'h1);
        @(negedge clk);
        chk({tag, "_gap"}, 32'({bus.rsp_valid, bus.mem_read, bus.mem_write, bus.req_ready}), 32'h0);
        @(negedge clk);
        chk({tag, "_ready_back"}, 32'(bus.req_ready), 32'h1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_strobes;
    } vec_t;

    vec_t vecs [10];

    initial begin : global_limit
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        logic [31:0] rd, e_rd;
        logic        er, e_er;
        int          sc, e_sc, n, low, gap_cycles, rsp_cnt;
        logic        wdone;
        logic        r_we;
        logic [31:0] r_addr, r_wdata;
        logic [3:0]  r_be;
        int          r_dly;

        vecs[0] = '{1'b0, 32'h0000_1236, 32'h0,         4'hF,    2,  32'hDEAD_BEEF, 1'b0, 3};
        vecs[1] = '{1'b1, 32'h0000_0040, 32'hA5A5_1234, 4'b0101, 0,  32'h0,         1'b0, 1};
        vecs[2] = '{1'b0, 32'h0000_0043, 32'h0,         4'h0,    1,  32'h11A5_3334, 1'b0, 2};
        vecs[3] = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF,    7,  32'h0,         1'b0, 8};
        vecs[4] = '{1'b0, 32'h0000_0102, 32'h0,         4'h0,    7,  32'hFFFF_FFFF, 1'b0, 8};
        vecs[5] = '{1'b0, 32'h0000_1234, 32'h0,         4'h0,    20, 32'h0,         1'b1, 8};
        vecs[6] = '{1'b1, 32'h0000_0100, 32'h0,         4'hF,    8,  32'h0,         1'b1, 8};
        vecs[7] = '{1'b0, 32'h0000_0101, 32'h0,         4'h0,    3,  32'hFFFF_FFFF, 1'b0, 4};
        vecs[8] = '{1'b1, 32'h0000_0041, 32'hFFFF_0000, 4'b1100, 4,  32'h0,         1'b0, 5};
        vecs[9] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0,    0,  32'hFFFF_3334, 1'b0, 1};

        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        ref_mem[12'h48D] = 32'hDEAD_BEEF;
        ref_mem[12'h010] = 32'h1122_3344;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'h1);
        chk("reset_flags", 32'({bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err}), 32'h0);
        chk("reset_addr", bus.mem_address, 32'h0);
        chk("reset_be_rdata", bus.rsp_rdata | 32'(bus.mem_byte_enable), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].be, vecs[i].delay, rd, er, sc);
            model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].delay,
                      e_rd, e_er, e_sc);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_strobes", i), 32'(sc), 32'(vecs[i].exp_strobes));
            if (!vecs[i].we || vecs[i].exp_err)
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // Back-to-back: valid held high, write then read to the same word.
        resp_delay    = 1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0200;
        bus.req_wdata = 32'hCAFE_F00D;
        bus.req_be    = 4'hF;
        @(negedge clk);
        bus.req_we = 1'b0;
        low = 0; gap_cycles = 0; wdone = 1'b0; n = 0;
        while (!bus.mem_read && n < 50) begin
            if (bus.mem_write) wdone = 1'b1;
            else if (wdone) begin
                low++;
                if (!bus.req_ready && !bus.rsp_valid) gap_cycles++;
            end
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b0;
        chk("b2b_low_cycles", 32'(low), 32'd3);
        chk("b2b_gap_cycles", 32'(gap_cycles), 32'd1);
        model_txn(1'b1, 32'h200, 32'hCAFE_F00D, 4'hF, 1, e_rd, e_er, e_sc);
        model_txn(1'b0, 32'h200, 32'h0, 4'h0, 1, e_rd, e_er, e_sc);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        chk("b2b_rdata_model", bus.rsp_rdata, e_rd);
        chk("b2b_err", 32'({bus.rsp_valid, bus.rsp_err}), 32'h2);
        repeat (2) @(negedge clk);

        // Reset asserted between edges while a write is waiting for mem_resp.
        resp_delay    = 50;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0300;
        bus.req_wdata = 32'h1234_5678;
        bus.req_be    = 4'hF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_mid_pre_write", 32'(bus.mem_write), 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_write_low", 32'(bus.mem_write), 32'h0);
        chk("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rsp_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_cnt++;
        end
        chk("rst_mid_rsp_count", 32'(rsp_cnt), 32'h0);
        run_txn("post_rst", 1'b0, 32'h0000_0300, 32'h0, 4'h0, 2, rd, er, sc);
        model_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 2, e_rd, e_er, e_sc);
        chk("post_rst_rdata", rd, e_rd);
        chk("post_rst_err", 32'(er), 32'h0);

        // Random traffic against the reference model.
        for (int k = 0; k < 40; k++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 32'($urandom_range(0, 255));
            r_wdata = $urandom;
            r_be    = 4'($urandom_range(0, 15));
            r_dly   = int'($urandom_range(0, 9));
            run_txn($sformatf("rnd%0d", k), r_we, r_addr, r_wdata, r_be, r_dly, rd, er, sc);
            model_txn(r_we, r_addr, r_wdata, r_be, r_dly, e_rd, e_er, e_sc);
            chk($sformatf("rnd%0d_err", k), 32'(er), 32'(e_er));
            chk($sformatf("rnd%0d_strobes", k), 32'(sc), 32'(e_sc));
            if (!r_we || e_er) chk($sformatf("rnd%0d_rdata", k), rd, e_rd);
        end

        chk("responder_bus_violation", 32'(bus_viol), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
